// File: rtl/shift_engine.sv
// -----------------------------------------------------------------------------
// shift_engine
//
// Parametrised multi-mode shift engine. A WIDTH-bit register is loaded in
// parallel and then shifted or rotated one bit per clock by a requested
// amount. Operations use a start/busy/done handshake and can be aborted.
//
// Modes (latched at start):
//   000 LSL  logical shift left, sin fills bit 0
//   001 LSR  logical shift right, sin fills the MSB
//   010 ASR  arithmetic shift right, the MSB is replicated
//   011 ROL  rotate left
//   100 ROR  rotate right
//   101..111 illegal: a one-cycle err pulse, no operation
//
// Ports:
//   clk_i     rising-edge clock
//   rst_ni    asynchronous reset, active low
//   wr_i      parallel load strobe (IDLE only, wins over start_i)
//   d_i       parallel load data
//   start_i   begin an operation (IDLE only)
//   mode_i    shift mode, see table above
//   amt_i     shift count, clamped to WIDTH
//   abort_i   cancel a running operation (SHIFT only)
//   sin_i     fill bit for LSL/LSR, sampled on every shift edge
//   q_o       register contents
//   sout_o    last bit shifted or rotated out
//   busy_o    operation in progress
//   done_o    one-cycle completion pulse
//   err_o     one-cycle illegal-mode pulse
// -----------------------------------------------------------------------------
module shift_engine #(
    parameter int WIDTH = 64,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             start_i,
    input  logic [2:0]       mode_i,
    input  logic [AW-1:0]    amt_i,
    input  logic             abort_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_o,
    output logic             sout_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [2:0] MODE_LSL = 3'b000;
    localparam logic [2:0] MODE_LSR = 3'b001;
    localparam logic [2:0] MODE_ASR = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    // Counts never exceed WIDTH, which fits in AW bits by construction.
    localparam logic [AW-1:0] CNT_MAX  = AW'(WIDTH);
    localparam logic [AW-1:0] CNT_ONE  = AW'(1);
    localparam logic [AW-1:0] CNT_ZERO = AW'(0);

    state_e           state_q;
    logic [WIDTH-1:0] data_q;
    logic             sout_q;
    logic [AW-1:0]    count_q;
    logic [2:0]       mode_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [WIDTH-1:0] data_d;
    logic             sout_d;
    logic [AW-1:0]    eff_cnt_d;
    logic             mode_legal_d;

    // Start-time decode: clamp the requested count and classify the mode.
    always_comb begin
        eff_cnt_d    = CNT_ZERO;
        mode_legal_d = 1'b0;
        if (amt_i > CNT_MAX) begin
            eff_cnt_d = CNT_MAX;
        end else begin
            eff_cnt_d = amt_i;
        end
        if (mode_i <= MODE_ROR) begin
            mode_legal_d = 1'b1;
        end else begin
            mode_legal_d = 1'b0;
        end
    end

    // One bit step of the latched mode; only consumed while in SHIFT.
    always_comb begin
        data_d = data_q;
        sout_d = sout_q;
        case (mode_q)
            MODE_LSL: begin
                data_d = {data_q[WIDTH-2:0], sin_i};
                sout_d = data_q[WIDTH-1];
            end
            MODE_LSR: begin
                data_d = {sin_i, data_q[WIDTH-1:1]};
                sout_d = data_q[0];
            end
            MODE_ASR: begin
                data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
                sout_d = data_q[0];
            end
            MODE_ROL: begin
                data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                sout_d = data_q[WIDTH-1];
            end
            MODE_ROR: begin
                data_d = {data_q[0], data_q[WIDTH-1:1]};
                sout_d = data_q[0];
            end
            default: begin
                // Illegal modes are never latched into SHIFT; hold as a
                // safe fallback.
                data_d = data_q;
                sout_d = sout_q;
            end
        endcase
    end

    // Control FSM with datapath and registered status flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            data_q  <= {WIDTH{1'b0}};
            sout_q  <= 1'b0;
            count_q <= CNT_ZERO;
            mode_q  <= MODE_LSL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // done and err are single-cycle pulses unless re-raised below.
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (wr_i) begin
                        data_q <= d_i;
                    end else if (start_i) begin
                        if (!mode_legal_d) begin
                            err_q <= 1'b1;
                        end else if (eff_cnt_d == CNT_ZERO) begin
                            mode_q  <= mode_i;
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            mode_q  <= mode_i;
                            count_q <= eff_cnt_d;
                            state_q <= ST_SHIFT;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (abort_i) begin
                        // Partial q and sout are kept; no step on this edge.
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        count_q <= CNT_ZERO;
                    end else begin
                        data_q  <= data_d;
                        sout_q  <= sout_d;
                        count_q <= count_q - CNT_ONE;
                        if (count_q == CNT_ONE) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    count_q <= CNT_ZERO;
                end
            endcase
        end
    end

    assign q_o    = data_q;
    assign sout_o = sout_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_shift_engine.sv
// -----------------------------------------------------------------------------
// tb_shift_engine
//
// Self-checking bench for shift_engine at WIDTH=8. Inputs are driven and
// outputs sampled on the falling clock edge. Expected results come from a
// closed-form model of each shift/rotate (shift operators and masks over
// the whole count), not from a per-bit step.
// -----------------------------------------------------------------------------
module tb_shift_engine;

    localparam int W  = 8;
    localparam int AW = 4;

    logic          clk_i;
    logic          rst_ni;
    logic          wr_i;
    logic [W-1:0]  d_i;
    logic          start_i;
    logic [2:0]    mode_i;
    logic [AW-1:0] amt_i;
    logic          abort_i;
    logic          sin_i;
    logic [W-1:0]  q_o;
    logic          sout_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q;
    logic       exp_sout;

    shift_engine #(.WIDTH(W)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wr_i    (wr_i),
        .d_i     (d_i),
        .start_i (start_i),
        .mode_i  (mode_i),
        .amt_i   (amt_i),
        .abort_i (abort_i),
        .sin_i   (sin_i),
        .q_o     (q_o),
        .sout_o  (sout_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .err_o   (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Result of n whole steps of mode m on q: {sout, q}. n is already clamped.
    function automatic logic [8:0] model(input logic [7:0] q, input logic [2:0] m,
                                         input int n, input logic s, input logic so);
        int qi, res, sb, r, fill;
        qi  = q;
        res = qi;
        sb  = so;
        r   = n % 8;
        if (n > 0) begin
            fill = (255 << (8 - n)) & 255;
            case (m)
                3'd0: begin
                    res = ((qi << n) | (s ? ((1 << n) - 1) : 0)) & 255;
                    sb  = (qi >> (8 - n)) & 1;
                end
                3'd1: begin
                    res = (qi >> n) | (s ? fill : 0);
                    sb  = (qi >> (n - 1)) & 1;
                end
                3'd2: begin
                    res = (qi >> n) | (q[7] ? fill : 0);
                    sb  = (qi >> (n - 1)) & 1;
                end
                3'd3: begin
                    res = ((qi << r) | (qi >> (8 - r))) & 255;
                    sb  = res & 1;
                end
                3'd4: begin
                    res = ((qi >> r) | (qi << (8 - r))) & 255;
                    sb  = (res >> 7) & 1;
                end
                default: begin
                    res = qi;
                    sb  = so;
                end
            endcase
        end
        return {sb[0], res[7:0]};
    endfunction

    task automatic load(input logic [7:0] v);
        wr_i = 1'b1;
        d_i  = v;
        @(negedge clk_i);
        wr_i = 1'b0;
        exp_q = v;
        check("load_q", q_o, exp_q);
    endtask

    // Issue one start and follow it cycle by cycle. abort_at<0 means no abort.
    task automatic run_op(input logic [2:0] m, input logic [3:0] a, input logic s,
                          input int abort_at, input bit wr_busy, input bit start_in_done);
        int n;
        int steps;
        logic [8:0] r;
        n = (a > 4'd8) ? 8 : int'(a);
        start_i = 1'b1;
        mode_i  = m;
        amt_i   = a;
        sin_i   = s;
        @(negedge clk_i);
        start_i = 1'b0;
        mode_i  = 3'($urandom);
        amt_i   = 4'($urandom);
        if (m > 3'd4) begin
            check("err_pulse", err_o, 32'd1);
            check("err_busy", busy_o, 32'd0);
            check("err_done", done_o, 32'd0);
            check("err_q", q_o, exp_q);
            @(negedge clk_i);
            check("err_clear", err_o, 32'd0);
            check("err_busy2", busy_o, 32'd0);
        end else if (n == 0) begin
            check("zero_done", done_o, 32'd1);
            check("zero_busy", busy_o, 32'd0);
            check("zero_q", q_o, exp_q);
            @(negedge clk_i);
            check("zero_done_end", done_o, 32'd0);
        end else begin
            steps = (abort_at >= 0 && abort_at < n) ? abort_at : n;
            for (int i = 0; i < steps; i++) begin
                check("busy_run", busy_o, 32'd1);
                check("done_run", done_o, 32'd0);
                if (wr_busy) begin
                    wr_i = 1'b1;
                    d_i  = 8'hFF;
                end
                @(negedge clk_i);
            end
            wr_i = 1'b0;
            if (steps < n) begin
                check("abort_busy_pre", busy_o, 32'd1);
                abort_i = 1'b1;
                @(negedge clk_i);
                abort_i = 1'b0;
                r = model(exp_q, m, steps, s, exp_sout);
                exp_q    = r[7:0];
                exp_sout = r[8];
                check("abort_busy", busy_o, 32'd0);
                check("abort_done", done_o, 32'd0);
                check("abort_q", q_o, exp_q);
                check("abort_sout", sout_o, exp_sout);
                @(negedge clk_i);
                check("abort_nodone", done_o, 32'd0);
                check("abort_q_hold", q_o, exp_q);
            end else begin
                r = model(exp_q, m, n, s, exp_sout);
                exp_q    = r[7:0];
                exp_sout = r[8];
                check("op_done", done_o, 32'd1);
                check("op_busy_end", busy_o, 32'd0);
                check("op_q", q_o, exp_q);
                check("op_sout", sout_o, exp_sout);
                if (start_in_done) begin
                    start_i = 1'b1;
                    mode_i  = 3'd0;
                    amt_i   = 4'd1;
                    @(negedge clk_i);
                    start_i = 1'b0;
                    check("dstart_busy", busy_o, 32'd0);
                    check("dstart_done", done_o, 32'd0);
                    check("dstart_q", q_o, exp_q);
                end else begin
                    @(negedge clk_i);
                    check("op_done_end", done_o, 32'd0);
                    check("op_idle_busy", busy_o, 32'd0);
                end
            end
        end
    endtask

    initial begin
        rst_ni   = 1'b0;
        wr_i     = 1'b0;
        d_i      = 8'h00;
        start_i  = 1'b0;
        mode_i   = 3'd0;
        amt_i    = 4'd0;
        abort_i  = 1'b0;
        sin_i    = 1'b0;
        exp_q    = 8'h00;
        exp_sout = 1'b0;

        // Reset state
        @(negedge clk_i);
        check("rst_q", q_o, 32'd0);
        check("rst_sout", sout_o, 32'd0);
        check("rst_busy", busy_o, 32'd0);
        check("rst_done", done_o, 32'd0);
        check("rst_err", err_o, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // LSL with fill
        load(8'h81);
        run_op(3'd0, 4'd3, 1'b1, -1, 1'b0, 1'b0);
        check("lsl_q_const", q_o, 32'h0F);
        check("lsl_sout_const", sout_o, 32'd0);

        // ASR, clamp, abort
        load(8'h90);
        run_op(3'd2, 4'd2, 1'b0, -1, 1'b0, 1'b0);
        check("asr_q_const", q_o, 32'hE4);
        load(8'h90);
        run_op(3'd1, 4'd15, 1'b0, -1, 1'b0, 1'b0);
        check("lsr_clamp_const", q_o, 32'h00);
        load(8'h90);
        run_op(3'd4, 4'd4, 1'b0, 2, 1'b0, 1'b0);
        check("ror_abort_const", q_o, 32'h24);

        // Rotate full circle
        load(8'hA5);
        run_op(3'd4, 4'd8, 1'b0, -1, 1'b0, 1'b0);
        check("ror8_q_const", q_o, 32'hA5);
        check("ror8_sout_const", sout_o, 32'd1);
        load(8'h80);
        run_op(3'd3, 4'd1, 1'b0, -1, 1'b0, 1'b0);
        check("rol1_q_const", q_o, 32'h01);
        check("rol1_sout_const", sout_o, 32'd1);

        // Illegal mode and zero count
        load(8'h3C);
        run_op(3'd6, 4'd3, 1'b0, -1, 1'b0, 1'b0);
        run_op(3'd0, 4'd0, 1'b1, -1, 1'b0, 1'b0);

        // wr and start together in IDLE
        wr_i    = 1'b1;
        d_i     = 8'hC3;
        start_i = 1'b1;
        mode_i  = 3'd0;
        amt_i   = 4'd2;
        @(negedge clk_i);
        wr_i    = 1'b0;
        start_i = 1'b0;
        exp_q   = 8'hC3;
        check("wrstart_q", q_o, exp_q);
        check("wrstart_busy", busy_o, 32'd0);
        @(negedge clk_i);
        check("wrstart_busy2", busy_o, 32'd0);
        check("wrstart_done", done_o, 32'd0);

        // wr during SHIFT ignored; start during DONE ignored, next start taken
        load(8'h5B);
        run_op(3'd1, 4'd5, 1'b1, -1, 1'b1, 1'b1);
        run_op(3'd3, 4'd3, 1'b0, -1, 1'b0, 1'b0);

        // Reset mid-operation
        load(8'hE7);
        start_i = 1'b1;
        mode_i  = 3'd0;
        amt_i   = 4'd6;
        sin_i   = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("mid_busy", busy_o, 32'd1);
        rst_ni = 1'b0;
        #1;
        check("mrst_q", q_o, 32'd0);
        check("mrst_busy", busy_o, 32'd0);
        check("mrst_done", done_o, 32'd0);
        check("mrst_sout", sout_o, 32'd0);
        #2;
        rst_ni   = 1'b1;
        exp_q    = 8'h00;
        exp_sout = 1'b0;
        @(negedge clk_i);
        check("post_rst_busy", busy_o, 32'd0);
        load(8'h5A);

        // Randomized operations against the model
        for (int it = 0; it < 60; it++) begin
            int ab;
            if ($urandom_range(0, 2) == 0) begin
                load(8'($urandom));
            end
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : -1;
            run_op(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                   1'($urandom), ab, 1'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_engine.md
# shift_engine

Parametrised multi-mode shift engine: a register loaded in parallel, then shifted or rotated by a requested amount, one bit per clock, under a start/busy/done handshake. Generalises the team's fixed 64-bit load/hold register with selectable width, five shift modes, serial fill, abort and error reporting. Sits between datapath producers and serial consumers such as bit-serial links, CRC feeders and barrel-shift replacements in area-constrained builds.

## Interface
- WIDTH, 64, register width in bits (≥2)
- AW, $clog2(WIDTH)+1, width of amt
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low
- wr  in  1  parallel load strobe
- d  in  WIDTH  parallel load data
- start  in  1  begin operation
- mode  in  3  000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, 101–111 illegal
- amt  in  AW  shift count
- abort  in  1  cancel running operation
- sin  in  1  fill bit for LSL/LSR
- q  out  WIDTH  register contents
- sout  out  1  last bit shifted or rotated out
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle illegal-mode pulse

## Operation
- States: IDLE, SHIFT, DONE. Reset (rst=0, asynchronous): state=IDLE, q=0, sout=0, busy=0, done=0, err=0, count=0.
- IDLE:
  - wr=1 → q<=d. wr has priority; start is ignored in the same cycle.
  - start=1, wr=0 → latch mode and the effective count N=min(amt, WIDTH).
    - mode illegal → err=1 for one cycle, stay IDLE, q unchanged.
    - N=0 → go to DONE, q unchanged.
    - otherwise → go to SHIFT with count=N.
- SHIFT (busy=1): every edge performs one bit step on q, sets sout to the exiting bit, and decrements count. The edge where count==1 moves to DONE.
  - LSL: q<={q[W-2:0],sin}, sout=q[W-1]
  - LSR: q<={sin,q[W-1:1]}, sout=q[0]
  - ASR: q<={q[W-1],q[W-1:1]}, sout=q[0]
  - ROL: q<={q[W-2:0],q[W-1]}, sout=q[W-1]
  - ROR: q<={q[0],q[W-1:1]}, sout=q[0]
- The latched mode is used for the whole operation. Changes to mode or amt while busy are ignored.
- DONE: done=1 for exactly one cycle, busy=0, then go to IDLE. start and wr are ignored in DONE.
- abort=1 in SHIFT → go to IDLE at the next edge. No step is performed on that edge. q and sout hold their partial values. No done pulse. abort is ignored in other states.
- wr and start while busy are ignored. They are not queued.
- sin is sampled on each shift edge, not latched at start.
- sout holds its value between operations and is unchanged by wr.

## Timing
- All outputs are registered. busy, done and err are decoded from state and registered flags with no combinational path from inputs.
- start accepted at edge k with N>0: busy=1 after k; shift steps on edges k+1..k+N; final q and done=1 after edge k+N; busy=0 from edge k+N (DONE state); IDLE after k+N+1.
- N=0: done=1 after edge k, IDLE after k+1.
- Earliest next start is sampled at edge k+N+2.
- A ROL or ROR with amt≥WIDTH returns the original q after WIDTH steps.
- rst asserted at any point, including mid-SHIFT or in DONE, clears everything immediately. After rst deasserts, the first edge behaves as IDLE.

## Test plan (WIDTH=8)
- Reset mid-operation: assert rst=0 during SHIFT → q=0, busy=0, done=0, sout=0 immediately; after release, wr d=0x5A → q=0x5A.
- LSL with fill: load 0x81, start LSL amt=3, sin=1 → busy for 3 cycles, q=0x0F, sout=0, one-cycle done exactly 3 edges after start.
- ASR, clamp and abort: load 0x90, ASR amt=2 → q=0xE4. Load 0x90, LSR amt=15 → clamped to 8, q=0x00 (sin=0), 8 busy cycles. Load 0x90, ROR amt=4 with abort after 2 shifts → q=0x24, no done.
- Rotate full circle: load 0xA5, ROR amt=8 → q=0xA5, sout=1. ROL amt=1 on 0x80 → q=0x01, sout=1.
- Edge cases: start with illegal mode 110 → err pulse, q unchanged, busy stays 0. amt=0 → done the next cycle, q unchanged. wr and start together in IDLE → q=d, no busy.
- Busy-time inputs: wr=1 d=0xFF during SHIFT → ignored, result unaffected. start during DONE → ignored; a new start in IDLE is accepted.
